// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, S-box math, word helpers,
// and the enums used by the inverse round-key generator.
package aes_pkg;

  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_SERVE
  } state_e;

  typedef enum logic {
    DIR_FWD,
    DIR_INV
  } dir_e;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the affine transform.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, v;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    v    = gf_mul(x252, x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_f(w[31:24]), sbox_f(w[23:16]),
            sbox_f(w[15:8]), sbox_f(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round_key_gen_step.sv
// One AES-128 key-schedule step, forward or inverse, sharing one SubWord.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rc_i,
  input  dir_e         dir_i,
  output logic [127:0] next_key_o
);

  logic [31:0] c0, c1, c2, c3;
  logic [31:0] t, r, s, w0;

  assign c0 = key_i[127:96];
  assign c1 = key_i[95:64];
  assign c2 = key_i[63:32];
  assign c3 = key_i[31:0];

  // Inverse direction recovers the previous w3 as c3^c2 first.
  assign t = (dir_i == DIR_INV) ? (c3 ^ c2) : c3;
  assign r = rot_word(t);

  for (genvar g = 0; g < 4; g++) begin : g_sb
    aes_sbox u_sbox (
      .a_i (r[8*g +: 8]),
      .s_o (s[8*g +: 8])
    );
  end

  assign w0 = c0 ^ s ^ {rc_i, 24'h0};

  always_comb begin
    next_key_o = '0;
    if (dir_i == DIR_INV) begin
      next_key_o = {w0, c1 ^ c0, c2 ^ c1, c3 ^ c2};
    end else begin
      next_key_o = {w0, c1 ^ w0, c2 ^ c1 ^ w0, c3 ^ c2 ^ c1 ^ w0};
    end
  end

endmodule

// File: rtl/aes_sbox.sv
// Single AES forward S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  assign s_o = sbox_f(a_i);

endmodule

// File: rtl/aes_inv_round_key_gen.sv
// Streams AES-128 round keys RK[10]..RK[0] by forward expansion
// followed by in-place inversion of the key schedule.
module aes_inv_round_key_gen
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         key_replay,
  output logic         key_busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  localparam logic [3:0] NR = 4'(AES_NR);

  state_e       state_q;
  logic [127:0] key_q, key_d, saved_q;
  logic         saved_valid_q;
  logic [3:0]   cnt_q, rk_round_q;
  logic         rk_valid_q;
  logic [7:0]   rc;
  dir_e         dir;

  assign dir = (state_q == ST_SERVE) ? DIR_INV : DIR_FWD;
  assign rc  = rcon((state_q == ST_SERVE) ? rk_round_q : cnt_q);

  aes_key_step u_step (
    .key_i      (key_q),
    .rc_i       (rc),
    .dir_i      (dir),
    .next_key_o (key_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      key_q         <= '0;
      saved_q       <= '0;
      saved_valid_q <= 1'b0;
      cnt_q         <= '0;
      rk_round_q    <= '0;
      rk_valid_q    <= 1'b0;
    end else if (key_load) begin
      key_q      <= key_in;
      cnt_q      <= 4'd1;
      state_q    <= ST_EXPAND;
      rk_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_replay && saved_valid_q) begin
            key_q      <= saved_q;
            rk_round_q <= NR;
            rk_valid_q <= 1'b1;
            state_q    <= ST_SERVE;
          end
        end
        ST_EXPAND: begin
          key_q <= key_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == NR) begin
            saved_q       <= key_d;
            saved_valid_q <= 1'b1;
            rk_round_q    <= NR;
            rk_valid_q    <= 1'b1;
            cnt_q         <= '0;
            state_q       <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (rk_valid_q && rk_ready) begin
            if (rk_round_q == 4'd0) begin
              rk_valid_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              key_q      <= key_d;
              rk_round_q <= rk_round_q - 4'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign key_busy = (state_q != ST_IDLE);
  assign rk_valid = rk_valid_q;
  assign rk_out   = key_q;
  assign rk_round = rk_round_q;
  assign rk_last  = rk_valid_q && (rk_round_q == 4'd0);

endmodule

// File: doc/aes_inv_round_key_gen.md
Name: aes_inv_round_key_gen

Overview:
Supplies AES-128 round keys to the decryption datapath in reverse order, RK[Nr] down to RK[0]. This is the counterpart of the encryption-side AddRoundKey/key-expansion path. A loaded cipher key is forward-expanded once to RK[Nr]. Keys are then produced one per accepted handshake by inverting the key schedule in place, so no 11-entry key store is needed. RK[Nr] is also saved so further blocks under the same key can be replayed without re-expansion.

Parameters:
Nk, 4, key length in 32-bit words; only 4 (AES-128) is supported.
Nr, 10, number of rounds; only 10 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
key_load  in  1  one-cycle pulse; samples key_in and starts forward expansion.
key_in  in  128  cipher key; word w0 = bits [127:96] (FIPS-197 byte order).
key_replay  in  1  pulse; restarts the reverse stream from the saved RK[Nr].
key_busy  out  1  high whenever state is not IDLE.
rk_valid  out  1  rk_out/rk_round hold a valid round key.
rk_ready  in  1  consumer accepts the key; a transfer occurs when rk_valid and rk_ready are both high.
rk_out  out  128  current round key.
rk_round  out  4  round index of rk_out (10 down to 0).
rk_last  out  1  equals rk_valid and (rk_round == 0).

Behaviour:
- Reset (asynchronous): state=IDLE; rk_valid=0, rk_out=0, rk_round=0, rk_last=0, key_busy=0; saved_valid=0, cnt=0.
- States: IDLE, EXPAND, SERVE.
- key_load is accepted in any state, aborts any activity, and has priority over key_replay and over a same-cycle transfer. The pending key is dropped without a transfer.
- On key_load: key_reg<=key_in, cnt<=1, state<=EXPAND, rk_valid<=0.
- EXPAND, each edge: key_reg<=fwd(key_reg, Rcon[cnt]), cnt<=cnt+1.
  - On the edge with cnt==Nr, also: saved_rk<=result, saved_valid<=1, rk_round<=Nr, rk_valid<=1, state<=SERVE.
  - Latency: rk_valid rises exactly Nr=10 edges after the edge that sampled key_load.
- SERVE, on a transfer:
  - If rk_round==0: rk_valid<=0, state<=IDLE.
  - Otherwise: key_reg<=inv(key_reg, Rcon[rk_round]), rk_round<=rk_round-1.
  - rk_valid stays high, giving one key per cycle under continuous ready.
- SERVE, without a transfer: rk_out and rk_round are held stable.
- key_replay:
  - Acts only in IDLE with saved_valid=1: key_reg<=saved_rk, rk_round<=Nr, rk_valid<=1, state<=SERVE (1-cycle latency).
  - Ignored in EXPAND, in SERVE, or when saved_valid=0.
- rk_out is driven directly from key_reg, with no added register stage.
- fwd(c, rc): n0=c0^SubWord(RotWord(c3))^{rc,24'h0}; n1=c1^n0; n2=c2^n1; n3=c3^n2.
- inv(c, rc): p3=c3^c2; p2=c2^c1; p1=c1^c0; p0=c0^SubWord(RotWord(p3))^{rc,24'h0}.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Rcon index 0 is unused.
- rk_round is never decremented below 0. cnt is cleared to 0 on leaving EXPAND.
- Reset mid-operation: all outputs return to reset values immediately, and saved_valid is cleared.

Decomposition:
- Shared package aes_pkg: Rcon table function, AES_NK/AES_NR constants, and the SubWord and RotWord functions. The S-box table comes from the existing shared aes_sbox.
- One natural sub-module: aes_key_step, a combinational block with inputs (key, rc, dir) and output next_key. dir selects fwd/inv, and both directions share one SubWord, i.e. 4 S-box instances.
- The FSM, counters, saved_rk and handshake stay in the top module.

Test Plan:
1. Forward expansion and first key (FIPS-197 C.1): load key 000102030405060708090a0b0c0d0e0f -> rk_valid rises 10 edges later with rk_round=10 and rk_out=13111d7fe3944a17f307a78b4d2b30c5.
2. Full reverse stream (FIPS-197 A.1): load 2b7e151628aed2a6abf7158809cf4f3c with rk_ready tied high.
   - Expected sequence: d014f9a8c9ee2589e13f0cc8b6630ca6, then ac7766f319fadc2128d12941575c006e, ... ending with 2b7e1516... at round 0.
   - rk_last is high only on round 0, and state returns to IDLE afterwards.
3. Backpressure: random rk_ready with about 30% duty -> rk_out/rk_round stay stable while not ready, no key is skipped or duplicated, and all 11 keys match the reference model.
4. Replay: after test 2 completes, pulse key_replay -> the next cycle shows rk_valid=1, rk_round=10, rk_out=d014f9a8...; key_replay right after reset -> ignored, rk_valid stays 0.
5. Abort: in SERVE at rk_round=6, assert key_load together with rk_ready -> no transfer, restart with new-key RK[10] after 10 edges; key_replay during EXPAND -> ignored.
6. Async reset: assert rst mid-EXPAND and mid-SERVE without a clock edge -> all outputs are 0 immediately; a subsequent replay is ignored.
